tluh_sram_arbiter: RTL and testbench



---
 rtl/tluh_sram_arbiter_if.sv | 62 ++++++
 rtl/tluh_sram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_tluh_sram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tluh_sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// tluh_sram_arbiter_if
//   Bundles the upstream requester side and the downstream SRAM side of
//   tluh_sram_arbiter into one interface.
//
//   Upstream (NumReq requesters, packed, requester k in slice k):
//     req_i, lock_i, we_i, addr_i, wdata_i, wmask_i  -> arbiter
//     gnt_o, rvalid_o (one-hot), rdata_o, rerror_o   <- arbiter (rdata/rerror broadcast)
//   Downstream (single SRAM port):
//     req_o, we_o, addr_o, wdata_o, wmask_o           <- arbiter
//     gnt_i, rvalid_i, rdata_i, rerror_i              -> arbiter
//   err_o: sticky "read response with nothing outstanding" flag.
//
//   Modports: slave = the arbiter, master = whatever drives the requests
//   and models the SRAM.
// ---------------------------------------------------------------------------
interface tluh_sram_arbiter_if #(
    parameter int NumReq = 2,
    parameter int SramDw = 32,
    parameter int SramAw = 12
);
    // Upstream
    logic [NumReq-1:0]        req_i;
    logic [NumReq-1:0]        lock_i;
    logic [NumReq-1:0]        we_i;
    logic [NumReq*SramAw-1:0] addr_i;
    logic [NumReq*SramDw-1:0] wdata_i;
    logic [NumReq*SramDw-1:0] wmask_i;
    logic [NumReq-1:0]        gnt_o;
    logic [NumReq-1:0]        rvalid_o;
    logic [SramDw-1:0]        rdata_o;
    logic [1:0]               rerror_o;

    // Downstream
    logic                     req_o;
    logic                     gnt_i;
    logic                     we_o;
    logic [SramAw-1:0]        addr_o;
    logic [SramDw-1:0]        wdata_o;
    logic [SramDw-1:0]        wmask_o;
    logic [SramDw-1:0]        rdata_i;
    logic                     rvalid_i;
    logic [1:0]               rerror_i;

    logic                     err_o;

    modport slave (
        input  req_i, lock_i, we_i, addr_i, wdata_i, wmask_i,
        input  gnt_i, rdata_i, rvalid_i, rerror_i,
        output gnt_o, rvalid_o, rdata_o, rerror_o,
        output req_o, we_o, addr_o, wdata_o, wmask_o,
        output err_o
    );

    modport master (
        output req_i, lock_i, we_i, addr_i, wdata_i, wmask_i,
        output gnt_i, rdata_i, rvalid_i, rerror_i,
        input  gnt_o, rvalid_o, rdata_o, rerror_o,
        input  req_o, we_o, addr_o, wdata_o, wmask_o,
        input  err_o
    );
endinterface

// File: rtl/tluh_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tluh_sram_arbiter
//   Shares one SRAM port between NumReq requesters. Round-robin, zero-latency
//   selection: the winner's request is forwarded to the SRAM in the cycle it
//   is selected. A per-requester lock keeps ownership across bursts/atomics.
//   Read responses are routed back in order through an id FIFO of depth
//   MaxOutstanding; a full FIFO blocks reads only, never writes.
//
//   Ports:
//     clk_i   clock
//     rst_ni  synchronous active-low reset
//     bus     tluh_sram_arbiter_if.slave (upstream + downstream signals)
// ---------------------------------------------------------------------------
module tluh_sram_arbiter #(
    parameter int NumReq         = 2,
    parameter int SramDw         = 32,
    parameter int SramAw         = 12,
    parameter int MaxOutstanding = 2
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    tluh_sram_arbiter_if.slave   bus
);

    localparam int IdW    = $clog2(NumReq);
    localparam int FifoAw = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW   = $clog2(MaxOutstanding + 1);

    typedef logic [IdW-1:0]    id_t;
    typedef logic [FifoAw-1:0] fptr_t;
    typedef enum logic {StIdle, StLocked} lock_state_e;

    // ----------------------------------------------------------------------
    // Registered state
    // ----------------------------------------------------------------------
    lock_state_e   state_q,  state_d;
    id_t           owner_q,  owner_d;
    id_t           ptr_q,    ptr_d;
    fptr_t         wr_ptr_q, wr_ptr_d;
    fptr_t         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q,  cnt_d;
    logic          err_q,    err_d;
    id_t           fifo_q [MaxOutstanding];
    id_t           fifo_d [MaxOutstanding];

    function automatic id_t inc_id(id_t v);
        return (v == id_t'(NumReq - 1)) ? '0 : v + id_t'(1);
    endfunction

    function automatic fptr_t inc_fptr(fptr_t v);
        return (v == fptr_t'(MaxOutstanding - 1)) ? '0 : v + fptr_t'(1);
    endfunction

    // ----------------------------------------------------------------------
    // Selection
    // ----------------------------------------------------------------------
    logic              fifo_full;
    logic              fifo_empty;
    logic [NumReq-1:0] eligible;
    logic              found;
    id_t               win;
    logic              accept;
    logic              push;
    logic              pop;
    id_t               head;

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // NOTE: every variable written in an always_comb gets a default before
    // any conditional assignment, otherwise a latch is inferred.
    always_comb begin
        int idx;
        eligible = '0;
        found    = 1'b0;
        win      = '0;
        idx      = 0;
        // Read eligibility looks at the registered count only, so a pop in
        // this cycle never unblocks a read in the same cycle.
        for (int k = 0; k < NumReq; k++) begin
            eligible[k] = bus.req_i[k] & (bus.we_i[k] | ~fifo_full) &
                          ((state_q == StIdle) | (owner_q == id_t'(k)));
        end
        // First eligible index scanning ptr, ptr+1, ... modulo NumReq.
        for (int i = 0; i < NumReq; i++) begin
            idx = (int'(ptr_q) + i) % NumReq;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = id_t'(idx);
            end
        end
    end

    assign accept = found & bus.gnt_i;
    assign push   = accept & ~bus.we_i[win];
    assign pop    = bus.rvalid_i & ~fifo_empty;

    // ----------------------------------------------------------------------
    // Outputs (request path and response routing are purely combinational)
    // ----------------------------------------------------------------------
    assign bus.req_o    = found;
    assign bus.we_o     = found & bus.we_i[win];
    assign bus.addr_o   = found ? bus.addr_i[int'(win)*SramAw +: SramAw]  : '0;
    assign bus.wdata_o  = found ? bus.wdata_i[int'(win)*SramDw +: SramDw] : '0;
    assign bus.wmask_o  = found ? bus.wmask_i[int'(win)*SramDw +: SramDw] : '0;
    assign bus.gnt_o    = accept ? (NumReq'(1) << win)  : '0;
    assign bus.rvalid_o = pop    ? (NumReq'(1) << head) : '0;
    assign bus.rdata_o  = bus.rdata_i;
    assign bus.rerror_o = bus.rerror_i;
    assign bus.err_o    = err_q;

    // ----------------------------------------------------------------------
    // Next-state logic
    // ----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        fifo_d   = fifo_q;
        err_d    = err_q | (bus.rvalid_i & fifo_empty);

        // Routing FIFO
        if (push) begin
            fifo_d[wr_ptr_q] = win;
            wr_ptr_d         = inc_fptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = inc_fptr(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Lock FSM and round-robin pointer
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.lock_i[win]) begin
                        // Pointer stays put while locked; it advances past
                        // the owner once the lock is released.
                        state_d = StLocked;
                        owner_d = win;
                    end else begin
                        ptr_d = inc_id(win);
                    end
                end
            end
            StLocked: begin
                // While locked only the owner can win, so accept implies
                // win == owner. An abandoned lock (no request, no lock) is
                // released even without a grant.
                if ((accept && !bus.lock_i[owner_q]) ||
                    (!bus.req_i[owner_q] && !bus.lock_i[owner_q])) begin
                    state_d = StIdle;
                    ptr_d   = inc_id(owner_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ----------------------------------------------------------------------
    // Registers
    // ----------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; an entry is only read
    // while the count says it holds a valid id, and the count is reset.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_tluh_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tluh_sram_arbiter
//   Self-checking bench for tluh_sram_arbiter. A behavioural model (integer
//   pointer, lock flag/owner, queue of outstanding ids) predicts the request
//   path every cycle; predicted read responses go into a scoreboard queue that
//   a separate monitor drains at the falling edge.
// ---------------------------------------------------------------------------
module tb_tluh_sram_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tluh_sram_arbiter_if #(.NumReq(N), .SramDw(DW), .SramAw(AW)) bus ();

    tluh_sram_arbiter #(
        .NumReq(N), .SramDw(DW), .SramAw(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // Stimulus for the next cycle
    logic [N-1:0]  s_req, s_lock, s_we;
    logic [AW-1:0] s_addr  [N];
    logic [DW-1:0] s_wdata [N];
    logic [DW-1:0] s_wmask [N];
    logic          s_gnt, s_rvalid, s_rst;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rerror;

    // Reference model state
    int  m_ptr;
    bit  m_locked;
    int  m_owner;
    int  m_q[$];
    bit  m_err;

    // Scoreboard
    typedef struct packed {
        logic [N-1:0]  id_oh;
        logic [DW-1:0] data;
        logic [1:0]    err;
    } resp_t;
    resp_t sb[$];

    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear();
        s_req = '0; s_lock = '0; s_we = '0; s_gnt = 1'b0;
        s_rvalid = 1'b0; s_rdata = '0; s_rerror = '0; s_rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            s_addr[k] = '0; s_wdata[k] = '0; s_wmask[k] = '0;
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0; m_err = 0;
        m_q.delete();
    endtask

    function automatic int model_winner();
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (s_req[k] && (s_we[k] || m_q.size() < MO) && (!m_locked || m_owner == k))
                return k;
        end
        return -1;
    endfunction

    // One clock: apply stimulus, check the request path, record the expected
    // response, then advance the model to match the coming edge.
    task automatic step();
        int            win;
        bit            acc;
        logic [N-1:0]  exp_gnt, oh;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata, exp_wmask;

        @(posedge clk);
        #1;
        rst_n        = ~s_rst;
        bus.req_i    = s_req;
        bus.lock_i   = s_lock;
        bus.we_i     = s_we;
        bus.gnt_i    = s_gnt;
        bus.rvalid_i = s_rvalid;
        bus.rdata_i  = s_rdata;
        bus.rerror_i = s_rerror;
        for (int k = 0; k < N; k++) begin
            bus.addr_i[k*AW +: AW]  = s_addr[k];
            bus.wdata_i[k*DW +: DW] = s_wdata[k];
            bus.wmask_i[k*DW +: DW] = s_wmask[k];
        end
        #3;

        win = model_winner();
        acc = (win >= 0) && s_gnt;
        exp_gnt = '0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wmask = '0;
        if (win >= 0) begin
            exp_we    = s_we[win];
            exp_addr  = s_addr[win];
            exp_wdata = s_wdata[win];
            exp_wmask = s_wmask[win];
            if (acc) exp_gnt[win] = 1'b1;
        end
        check("req_path",
              {bus.req_o, bus.gnt_o, bus.we_o, bus.addr_o, bus.wdata_o, bus.wmask_o},
              {win >= 0,  exp_gnt,   exp_we,   exp_addr,   exp_wdata,   exp_wmask});
        check("bcast_err", {bus.rdata_o, bus.rerror_o, bus.err_o},
                           {s_rdata,     s_rerror,     m_err});

        if (s_rvalid && m_q.size() > 0) begin
            oh = '0;
            oh[m_q[0]] = 1'b1;
            sb.push_back('{id_oh: oh, data: s_rdata, err: s_rerror});
        end

        if (s_rst) begin
            model_reset();
        end else begin
            if (s_rvalid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else                m_err = 1;
            end
            if (acc && !s_we[win]) m_q.push_back(win);
            if (!m_locked) begin
                if (acc) begin
                    if (s_lock[win]) begin
                        m_locked = 1; m_owner = win;
                    end else begin
                        m_ptr = (win + 1) % N;
                    end
                end
            end else if ((acc && !s_lock[m_owner]) || (!s_req[m_owner] && !s_lock[m_owner])) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic drain();
        clear();
        while (m_q.size() > 0) begin
            s_rvalid = 1'b1;
            s_rdata  = $urandom;
            s_rerror = 2'($urandom);
            step();
        end
        clear();
    endtask

    // Response monitor: every response is zero-latency, so each scoreboard
    // entry must be matched by rvalid_o in the cycle it was predicted.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb.size() == 0) begin
                    if (bus.rvalid_o !== '0) check("rvalid_spurious", bus.rvalid_o, '0);
                end else begin
                    resp_t e;
                    e = sb.pop_front();
                    check("rsp", {bus.rvalid_o, bus.rdata_o, bus.rerror_o}, e);
                end
            end
        end
    end

    initial begin
        clear();
        rst_n        = 1'b0;
        bus.req_i    = '0; bus.lock_i = '0; bus.we_i = '0;
        bus.addr_i   = '0; bus.wdata_i = '0; bus.wmask_i = '0;
        bus.gnt_i    = 1'b0; bus.rvalid_i = 1'b0;
        bus.rdata_i  = '0; bus.rerror_i = '0;
        repeat (2) @(posedge clk);
        model_reset();
        mon_en = 1;

        // Idle after reset: everything zero
        clear(); step();

        // Single read from requester 0, response next cycle
        clear(); s_req = 2'b01; s_addr[0] = 12'h4; s_gnt = 1'b1; step();
        clear(); s_rvalid = 1'b1; s_rdata = 32'h1; step();

        // Both requesters reading back-to-back, single-cycle SRAM return
        for (int i = 0; i < 6; i++) begin
            clear();
            s_req = 2'b11; s_gnt = 1'b1;
            s_addr[0] = AW'($urandom); s_addr[1] = AW'($urandom);
            s_rvalid = (m_q.size() > 0); s_rdata = $urandom;
            step();
        end
        drain();

        // Atomic RMW from requester 0 while requester 1 keeps writing
        clear(); s_gnt = 1'b1; s_req = 2'b11; s_we = 2'b10; s_lock = 2'b01;
        s_addr[0] = 12'hC; s_addr[1] = 12'h20; s_wdata[1] = 32'hAA; s_wmask[1] = '1;
        step();
        s_rvalid = (m_q.size() > 0); s_rdata = 32'h77;
        s_we = 2'b11; s_lock = 2'b00; s_wdata[0] = 32'h5; s_wmask[0] = '1;
        step();
        s_rvalid = (m_q.size() > 0); s_req = 2'b10;
        step();
        drain();

        // Downstream stall: selection holds, nothing changes, then granted
        clear(); s_req = 2'b11; s_addr[0] = 12'h10; s_addr[1] = 12'h11;
        repeat (3) step();
        s_gnt = 1'b1; step();
        drain();

        // Full FIFO blocks reads but not writes
        clear(); s_gnt = 1'b1; s_req = 2'b01; step(); step();
        s_req = 2'b11; s_we = 2'b10; s_wdata[1] = 32'hBEEF; s_wmask[1] = 32'hFFFF;
        step();
        s_req = 2'b01; s_we = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h12345678;
        step();
        s_rvalid = 1'b0; step();
        drain();

        // Response with nothing outstanding, sticky error, reset under lock
        clear(); s_rvalid = 1'b1; s_rdata = 32'hDEAD; step();
        clear(); step();
        clear(); s_req = 2'b01; s_lock = 2'b01; s_gnt = 1'b1; step();
        clear(); s_req = 2'b01; s_lock = 2'b01; s_rst = 1'b1; step();
        clear(); s_req = 2'b10; s_gnt = 1'b1; s_we = 2'b10; step();
        clear(); s_rvalid = 1'b1; step();
        clear(); s_rst = 1'b1; step();
        clear(); step();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            clear();
            s_req  = N'($urandom);
            s_we   = N'($urandom);
            for (int k = 0; k < N; k++) begin
                s_lock[k]  = ($urandom_range(0, 3) == 0);
                s_addr[k]  = AW'($urandom);
                s_wdata[k] = $urandom;
                s_wmask[k] = $urandom;
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            s_rerror = 2'($urandom);
            s_rst    = (i == 1500);
            step();
        end
        drain();
        clear(); step();
        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
